nanorv32_periph_arbiter: RTL
============================

NANORV32_PERIPH_ARBITER -- requirements
Module: nanorv32_periph_arbiter

Interface
REQ-001 SHALL take parameter NANORV32_PERIPH_ADDR_MSB, default 31, MSB of peripheral address buses.
REQ-002 SHALL take parameter NANORV32_DATA_MSB, default 31, MSB of peripheral data buses.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 m0_periph_addr / m1_periph_addr  in  ADDR_MSB+1  master 0 (CPU) / master 1 (DMA) address.
REQ-006 m0_periph_bytesel / m1_periph_bytesel  in  4  byte enables.
REQ-007 m0_periph_din / m1_periph_din  in  DATA_MSB+1  write data.
REQ-008 m0_periph_en / m1_periph_en  in  1  request; held with addr/bytesel/din stable until own ready_nxt seen high.
REQ-009 m0_periph_dout / m1_periph_dout  out  DATA_MSB+1  read data, valid the cycle after own ready_nxt.
REQ-010 m0_periph_ready_nxt / m1_periph_ready_nxt  out  1  transfer completes this cycle.
REQ-011 periph_addr, periph_bytesel, periph_din, periph_en  out  same widths  shared bus toward peripheral mux.
REQ-012 periph_dout  in  DATA_MSB+1; periph_ready_nxt  in  1  shared-bus response.

Function
REQ-013 SHALL keep FSM states IDLE, BUSY0, BUSY1 plus registers last_grant (1 bit) and rsp_owner/rsp_valid (2 bits).
REQ-014 IDLE grant: only m0_en -> m0; only m1_en -> m1; both -> master != last_grant; neither -> no grant.
REQ-015 BUSYx grant: master x unconditionally; other master's en ignored.
REQ-016 Granted master's addr/bytesel/din/en SHALL drive shared bus combinationally (zero added latency); no grant -> all shared outputs 0.
REQ-017 Granted master's ready_nxt = periph_ready_nxt; non-granted master's ready_nxt = 0.
REQ-018 IDLE with grant x and periph_ready_nxt=1: stay IDLE, last_grant<=x (single-cycle transfer).
REQ-019 IDLE with grant x and periph_ready_nxt=0: next state BUSYx, last_grant<=x.
REQ-020 BUSYx with periph_ready_nxt=1: next state IDLE; new arbitration in following cycle.
REQ-021 BUSYx with mx_en=0 (abort): shared en=0 this cycle, next state IDLE, no ready_nxt to any master.
REQ-022 On completion for x: rsp_owner<=x, rsp_valid<=1 for exactly one cycle; otherwise rsp_valid<=0.
REQ-023 mx_periph_dout = periph_dout when rsp_valid and rsp_owner==x, else 0.
REQ-024 Back-to-back contention SHALL alternate: no master granted twice in a row while the other requests in IDLE.
REQ-025 periph_ready_nxt high with no grant SHALL be ignored (no state change, no ready_nxt out, rsp_valid<=0).

Reset
REQ-026 rst=1 SHALL force next state IDLE, last_grant<=1 (m0 wins first tie), rsp_valid<=0, rsp_owner<=0, overriding any in-flight transfer.
REQ-027 During and after reset, with no request: all shared-bus outputs, both ready_nxt and both dout = 0.
REQ-028 Transfer interrupted by reset SHALL not complete; masters re-issue after rst falls.

Verification
REQ-029 Reset, then m0_en=1 addr=0x10 bytesel=0xF, periph_ready_nxt=1 same cycle -> periph_en=1 periph_addr=0x10, m0_ready_nxt=1; next cycle periph_dout=0xA5A5A5A5 -> m0_dout=0xA5A5A5A5, m1_dout=0.
REQ-030 Both en=1 after reset, ready_nxt=1 every cycle -> grants m0, m1, m0, m1 on four consecutive cycles.
REQ-031 m1 granted with 3 wait cycles (ready_nxt low 3 cycles), m0_en raised in wait cycle 1 -> bus stays on m1 addr, m0_ready_nxt=0 until m1 completes; m0 granted the next cycle.
REQ-032 m0 in BUSY0 drops en before ready_nxt -> periph_en=0 that cycle, IDLE next, m0_ready_nxt never asserted; pending m1 granted next cycle.
REQ-033 rst=1 during BUSY1 -> IDLE next cycle, all outputs 0; after release, simultaneous requests -> m0 granted first.
REQ-034 periph_ready_nxt=1 with no en -> no ready_nxt to either master, both dout 0 next cycle.

Source files
------------

// File: rtl/nanorv32_periph_arbiter.sv
// Two-master (CPU = m0, DMA = m1) arbiter onto a shared peripheral bus.
// Grants are combinational; the response owner is registered to route read data.
module nanorv32_periph_arbiter #(
   parameter int NANORV32_PERIPH_ADDR_MSB = 31,
   parameter int NANORV32_DATA_MSB        = 31
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NANORV32_PERIPH_ADDR_MSB:0]   m0_periph_addr,
   input  logic [3:0]                          m0_periph_bytesel,
   input  logic [NANORV32_DATA_MSB:0]          m0_periph_din,
   input  logic                                m0_periph_en,
   output logic [NANORV32_DATA_MSB:0]          m0_periph_dout,
   output logic                                m0_periph_ready_nxt,
   input  logic [NANORV32_PERIPH_ADDR_MSB:0]   m1_periph_addr,
   input  logic [3:0]                          m1_periph_bytesel,
   input  logic [NANORV32_DATA_MSB:0]          m1_periph_din,
   input  logic                                m1_periph_en,
   output logic [NANORV32_DATA_MSB:0]          m1_periph_dout,
   output logic                                m1_periph_ready_nxt,
   output logic [NANORV32_PERIPH_ADDR_MSB:0]   periph_addr,
   output logic [3:0]                          periph_bytesel,
   output logic [NANORV32_DATA_MSB:0]          periph_din,
   output logic                                periph_en,
   input  logic [NANORV32_DATA_MSB:0]          periph_dout,
   input  logic                                periph_ready_nxt
);

   typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

   state_t state_reg, state_next;
   logic   last_grant_reg, last_grant_next;
   logic   rsp_owner_reg;
   logic   rsp_valid_reg;

   logic [NANORV32_PERIPH_ADDR_MSB:0] m_addr    [2];
   logic [3:0]                        m_bytesel [2];
   logic [NANORV32_DATA_MSB:0]        m_din     [2];
   logic [NANORV32_DATA_MSB:0]        m_dout    [2];
   logic [1:0]                        m_en;
   logic [1:0]                        m_ready;

   logic grant_valid;
   logic grant_sel;
   logic sel_en;
   logic complete;

   assign m_addr[0]    = m0_periph_addr;
   assign m_addr[1]    = m1_periph_addr;
   assign m_bytesel[0] = m0_periph_bytesel;
   assign m_bytesel[1] = m1_periph_bytesel;
   assign m_din[0]     = m0_periph_din;
   assign m_din[1]     = m1_periph_din;
   assign m_en         = {m1_periph_en, m0_periph_en};

   // A busy state pins the grant even if its master drops en (abort).
   always_comb begin
      grant_valid = 1'b0;
      grant_sel   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (m_en[0] && m_en[1]) begin
               grant_valid = 1'b1;
               grant_sel   = ~last_grant_reg;
            end else if (m_en[0]) begin
               grant_valid = 1'b1;
               grant_sel   = 1'b0;
            end else if (m_en[1]) begin
               grant_valid = 1'b1;
               grant_sel   = 1'b1;
            end
         end
         BUSY0: begin
            grant_valid = 1'b1;
            grant_sel   = 1'b0;
         end
         BUSY1: begin
            grant_valid = 1'b1;
            grant_sel   = 1'b1;
         end
         default: begin
            grant_valid = 1'b0;
            grant_sel   = 1'b0;
         end
      endcase
   end

   assign sel_en   = grant_valid && m_en[grant_sel];
   assign complete = sel_en && periph_ready_nxt;

   assign periph_addr    = grant_valid ? m_addr[grant_sel]    : '0;
   assign periph_bytesel = grant_valid ? m_bytesel[grant_sel] : '0;
   assign periph_din     = grant_valid ? m_din[grant_sel]     : '0;
   assign periph_en      = sel_en;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         assign m_ready[gi] = complete && (grant_sel == 1'(gi));
         assign m_dout[gi]  = (rsp_valid_reg && (rsp_owner_reg == 1'(gi))) ? periph_dout : '0;
      end
   endgenerate

   assign m0_periph_ready_nxt = m_ready[0];
   assign m1_periph_ready_nxt = m_ready[1];
   assign m0_periph_dout      = m_dout[0];
   assign m1_periph_dout      = m_dout[1];

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               last_grant_next = grant_sel;
               if (!periph_ready_nxt)
                  state_next = grant_sel ? BUSY1 : BUSY0;
            end
         end
         BUSY0, BUSY1: begin
            if (!sel_en || periph_ready_nxt)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         rsp_valid_reg  <= 1'b0;
         rsp_owner_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         rsp_valid_reg  <= complete;
         if (complete)
            rsp_owner_reg <= grant_sel;
      end
   end

endmodule
